// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: control FSM for the iterative multiply/divide datapath.
// Loads operands for one cycle, steps the datapath for ITERS cycles, then
// pulses result_rdy for one cycle. A divide by zero, or a multiply and a
// divide requested together, end the operation early with exception set.
// A new single request is accepted in any state and restarts the sequence.
// Every output is a flop, loaded from the next-state values.
module multdiv_sequencer #(
    parameter int ITERS  = 32,
    parameter int STEP_W = 6
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ctrl_mult,
    input  logic              ctrl_div,
    input  logic              divisor_zero,
    output logic              busy,
    output logic              op_div,
    output logic              load,
    output logic              step_en,
    output logic [STEP_W-1:0] step,
    output logic              result_rdy,
    output logic              exception
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ITERS - 1);
    localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};

    state_t            state;
    state_t            state_nxt;
    logic [STEP_W-1:0] step_nxt;
    logic              op_div_nxt;
    logic              exception_nxt;
    logic              dual_req;
    logic              single_req;

    assign dual_req   = ctrl_mult & ctrl_div;
    assign single_req = ctrl_mult ^ ctrl_div;

    // Next-state logic: requests override the current state, otherwise sequence normally.
    always_comb begin
        state_nxt     = state;
        step_nxt      = step;
        op_div_nxt    = op_div;
        exception_nxt = exception;
        if (dual_req) begin
            // Conflicting request: drop whatever is in flight and report an error result.
            state_nxt     = DONE;
            step_nxt      = STEP_ZERO;
            exception_nxt = 1'b1;
        end else if (single_req) begin
            state_nxt     = LOAD;
            op_div_nxt    = ctrl_div;
            step_nxt      = STEP_ZERO;
            exception_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt     = IDLE;
                    step_nxt      = STEP_ZERO;
                    exception_nxt = 1'b0;
                end
                LOAD: begin
                    step_nxt = STEP_ZERO;
                    if (op_div && divisor_zero) begin
                        state_nxt     = DONE;
                        exception_nxt = 1'b1;
                    end else begin
                        state_nxt     = RUN;
                        exception_nxt = 1'b0;
                    end
                end
                RUN: begin
                    if (step == STEP_LAST) begin
                        // Step returns to zero so IDLE always sees step == 0.
                        state_nxt     = DONE;
                        step_nxt      = STEP_ZERO;
                        exception_nxt = 1'b0;
                    end else begin
                        state_nxt = RUN;
                        step_nxt  = step + {{(STEP_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    state_nxt     = IDLE;
                    step_nxt      = STEP_ZERO;
                    exception_nxt = 1'b0;
                end
                default: begin
                    state_nxt     = IDLE;
                    step_nxt      = STEP_ZERO;
                    exception_nxt = 1'b0;
                end
            endcase
        end
    end

    // State, operation registers and strobes, all decoded from the next state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            step       <= STEP_ZERO;
            op_div     <= 1'b0;
            exception  <= 1'b0;
            busy       <= 1'b0;
            load       <= 1'b0;
            step_en    <= 1'b0;
            result_rdy <= 1'b0;
        end else begin
            state      <= state_nxt;
            step       <= step_nxt;
            op_div     <= op_div_nxt;
            exception  <= exception_nxt;
            busy       <= (state_nxt == LOAD) || (state_nxt == RUN);
            load       <= (state_nxt == LOAD);
            step_en    <= (state_nxt == RUN);
            result_rdy <= (state_nxt == DONE);
        end
    end

endmodule
